// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a done strobe.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic                 is_div_q;
    logic                 neg_q;
    logic                 rem_neg_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 dbz_q;

    logic                 is_div_in, signed_in, a_neg, b_neg, zero_div;
    logic                 accept, last_iter;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    // Operand decode; signed ops work on magnitudes and fix the sign at the end.
    always_comb begin
        is_div_in = op[1];
        signed_in = ~op[0];
        a_neg     = signed_in & a[WIDTH-1];
        b_neg     = signed_in & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
        zero_div  = is_div_in && (b == '0);
        accept    = start && !flush && ((state_q == IDLE) || (state_q == DONE));
        last_iter = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH-1));
    end

    // Multiply keeps the multiplier in the low half and shifts it out as the product grows.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];
        div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};
        acc_step  = is_div_q ? div_next : mul_next;
        mul_res   = neg_q ? (~acc_step + 1'b1) : acc_step;
        quot_fix  = neg_q ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
        rem_fix   = rem_neg_q ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1)
                              : acc_step[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = zero_div ? DONE : CALC;
                CALC:    if (last_iter) state_d = DONE;
                DONE:    state_d = start ? (zero_div ? DONE : CALC) : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    // Result registers only change on entry to DONE, so a flush leaves HI/LO intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            is_div_q  <= is_div_in;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= is_div_in & a_neg;
            if (is_div_in) begin
                acc_q  <= {{WIDTH{1'b0}}, a_mag};
                opnd_q <= b_mag;
            end else begin
                acc_q  <= {{WIDTH{1'b0}}, b_mag};
                opnd_q <= a_mag;
            end
            if (zero_div) begin
                hi_q  <= a;
                lo_q  <= '1;
                dbz_q <= 1'b1;
            end
        end else if ((state_q == CALC) && !flush) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                dbz_q <= 1'b0;
                if (is_div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quot_fix;
                end else begin
                    hi_q <= mul_res[2*WIDTH-1:WIDTH];
                    lo_q <= mul_res[WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        hi_out      = hi_q;
        lo_out      = lo_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Cycle n means the interval after rising edge n; start is sampled at edge 0.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hiOut;
    logic [31:0] loOut;
    logic        divByZero;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi_out      (hiOut),
        .lo_out      (loOut),
        .div_by_zero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one start request across edge 0; returns in cycle 1.
    task automatic issue(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #23;
        checks++;
        if ({busy, done, divByZero, hiOut, loOut} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero",
                     busy, done, divByZero, hiOut, loOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tickN(3);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_multu_full();
        int busyBad = 0;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int c = 1; c <= 32; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) busyBad++;
            tick();
        end
        checks++;
        if (busyBad != 0) begin
            errors++;
            $display("[TB] FAIL multu_busy_window: got %0d bad cycles in 1..32, expected 0", busyBad);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multu_done_at_33: got done=%b busy=%b, expected 1 0", done, busy);
        end
        checks++;
        if (hiOut !== 32'hFFFFFFFE || loOut !== 32'h00000001 || divByZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multu_result: got hi=%h lo=%h dbz=%b, expected fffffffe 00000001 0",
                     hiOut, loOut, divByZero);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multu_done_pulse: got done=%b at cycle 34, expected 0", done);
        end
    endtask

    task automatic test_mult_signed_divu();
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        tickN(32);
        checks++;
        if (done !== 1'b1 || hiOut !== 32'hFFFFFFFF || loOut !== 32'hFFFFFFEB) begin
            errors++;
            $display("[TB] FAIL mult_neg3x7: got done=%b hi=%h lo=%h, expected 1 ffffffff ffffffeb",
                     done, hiOut, loOut);
        end
        tick();
        issue(OP_DIVU, 32'd100, 32'd7);
        tickN(32);
        checks++;
        if (done !== 1'b1 || hiOut !== 32'h00000002 || loOut !== 32'h0000000E) begin
            errors++;
            $display("[TB] FAIL divu_100_7: got done=%b hi=%h lo=%h, expected 1 00000002 0000000e",
                     done, hiOut, loOut);
        end
        tick();
    endtask

    task automatic test_div_signed();
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        tickN(32);
        checks++;
        if (done !== 1'b1 || hiOut !== 32'hFFFFFFFF || loOut !== 32'hFFFFFFFD) begin
            errors++;
            $display("[TB] FAIL div_neg7_2: got done=%b hi=%h lo=%h, expected 1 ffffffff fffffffd",
                     done, hiOut, loOut);
        end
        tick();
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        tickN(32);
        checks++;
        if (done !== 1'b1 || hiOut !== 32'h00000000 || loOut !== 32'h80000000) begin
            errors++;
            $display("[TB] FAIL div_overflow_wrap: got done=%b hi=%h lo=%h, expected 1 00000000 80000000",
                     done, hiOut, loOut);
        end
        tick();
    endtask

    task automatic test_div_by_zero();
        issue(OP_DIV, 32'h00001234, 32'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || divByZero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dbz_done_at_1: got done=%b busy=%b dbz=%b, expected 1 0 1",
                     done, busy, divByZero);
        end
        checks++;
        if (hiOut !== 32'h00001234 || loOut !== 32'hFFFFFFFF) begin
            errors++;
            $display("[TB] FAIL dbz_result: got hi=%h lo=%h, expected 00001234 ffffffff", hiOut, loOut);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz_done_pulse: got done=%b, expected 0", done);
        end
        issue(OP_MULTU, 32'd2, 32'd3);
        tickN(32);
        checks++;
        if (done !== 1'b1 || divByZero !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd6) begin
            errors++;
            $display("[TB] FAIL dbz_cleared_next_op: got done=%b dbz=%b hi=%h lo=%h, expected 1 0 00000000 00000006",
                     done, divByZero, hiOut, loOut);
        end
        tick();
    endtask

    task automatic test_flush();
        int doneSeen = 0;
        issue(OP_MULTU, 32'h0000FFFF, 32'h0000FFFF);
        tickN(4);
        // Cycle 5: a start that would be a divide-by-zero if it were accepted.
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd5;
        b     = 32'd0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_start_ignored: got busy=%b done=%b at cycle 6, expected 1 0", busy, done);
        end
        tickN(4);
        flush = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_busy_cycle10: got busy=%b, expected 1", busy);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_busy_cycle11: got busy=%b, expected 0", busy);
        end
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) doneSeen++;
            tick();
        end
        checks++;
        if (doneSeen != 0) begin
            errors++;
            $display("[TB] FAIL flush_no_done: got %0d active cycles after flush, expected 0", doneSeen);
        end
        checks++;
        if (hiOut !== 32'd0 || loOut !== 32'd6 || divByZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_hilo_kept: got hi=%h lo=%h dbz=%b, expected 00000000 00000006 0",
                     hiOut, loOut, divByZero);
        end
    endtask

    task automatic test_reset_mid_calc();
        int activeSeen = 0;
        issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
        tickN(19);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midcalc_busy_cycle20: got busy=%b, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, divByZero, hiOut, loOut} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL midcalc_reset_outputs: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero",
                     busy, done, divByZero, hiOut, loOut);
        end
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) activeSeen++;
        end
        checks++;
        if (activeSeen != 0) begin
            errors++;
            $display("[TB] FAIL midcalc_no_done_after_release: got %0d active cycles, expected 0", activeSeen);
        end
    endtask

    task automatic test_back_to_back();
        issue(OP_MULTU, 32'd6, 32'd7);
        tickN(32);
        checks++;
        if (done !== 1'b1 || hiOut !== 32'd0 || loOut !== 32'd42) begin
            errors++;
            $display("[TB] FAIL b2b_first: got done=%b hi=%h lo=%h, expected 1 00000000 0000002a",
                     done, hiOut, loOut);
        end
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_busy_after_done: got busy=%b done=%b, expected 1 0", busy, done);
        end
        tickN(31);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_not_early: got done=%b busy=%b at cycle 65, expected 0 1", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || hiOut !== 32'd2 || loOut !== 32'd14) begin
            errors++;
            $display("[TB] FAIL b2b_second: got done=%b hi=%h lo=%h, expected 1 00000002 0000000e",
                     done, hiOut, loOut);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_return_idle: got done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_multu_full();
        test_mult_signed_divu();
        test_div_signed();
        test_div_by_zero();
        test_flush();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
